// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide memory-bus responder. It holds the RAM, the
// TX FIFO, the RX byte port, a free-running cycle counter with a coherent
// read snapshot, and the sticky program-stop latch.
module ram_io_responder #(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int unsigned PW        = $clog2(TX_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  logic [7:0]        mem  [RAM_WORDS];
  logic [7:0]        fifo [TX_DEPTH];
  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, cnt_next;
  logic [31:0]       cycle_cnt, snapshot;
  logic              stop_pend;

  logic              is_io, rd_acc, wr_acc;
  logic [2:0]        io_sel;
  logic [RAM_AW-1:0] ram_addr;
  logic              cpu_push, stop_wr, not_full, pop, push_req, push_ok;
  logic [7:0]        push_data, rdata_next;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus_a[31:18];

  // Bus decode and FIFO push/pop arbitration
  always_comb begin
    is_io     = (bus_a[17:16] == 2'b11);
    io_sel    = bus_a[2:0];
    ram_addr  = bus_a[RAM_AW-1:0];
    rd_acc    = rdy_in & ~bus_wr;
    wr_acc    = rdy_in & bus_wr;
    cpu_push  = wr_acc & is_io & (io_sel == 3'd0) & (|bus_wdata);
    stop_wr   = wr_acc & is_io & (io_sel == 3'd4);
    fifo_cnt  = wr_ptr - rd_ptr;
    not_full  = (fifo_cnt < CW'(TX_DEPTH));
    pop       = tx_valid & tx_ready;
    push_req  = cpu_push | stop_pend;
    push_ok   = push_req & not_full;
    push_data = cpu_push ? bus_wdata : 8'h00;
    cnt_next  = fifo_cnt + CW'(push_ok) - CW'(pop);
    rx_pop    = rd_acc & is_io & (io_sel == 3'd0) & rx_valid;
    tx_data   = fifo[rd_ptr[PW-1:0]];
  end

  // Read data selection for an accepted read
  always_comb begin
    rdata_next = 8'h00;
    if (!is_io) begin
      rdata_next = mem[ram_addr];
    end else begin
      case (io_sel)
        3'd0:    rdata_next = rx_valid ? rx_data : 8'h00;
        3'd4:    rdata_next = cycle_cnt[7:0];
        3'd5:    rdata_next = snapshot[15:8];
        3'd6:    rdata_next = snapshot[23:16];
        3'd7:    rdata_next = snapshot[31:24];
        default: rdata_next = 8'h00;
      endcase
    end
  end

  // RAM storage; contents survive reset
  always_ff @(posedge clk_in) begin
    if (wr_acc && !is_io) mem[ram_addr] <= bus_wdata;
  end

  // TX FIFO storage
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo[wr_ptr[PW-1:0]] <= push_data;
  end

  // Control state: pointers, flags, counter, snapshot, read data
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus_rdata      <= 8'h00;
      tx_valid       <= 1'b0;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      stop_pend      <= 1'b0;
      cycle_cnt      <= 32'd0;
      snapshot       <= 32'd0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      cycle_cnt      <= cycle_cnt + 32'd1;
      tx_valid       <= (cnt_next != '0);
      io_buffer_full <= (cnt_next == CW'(TX_DEPTH));
      if (rd_acc) bus_rdata <= rdata_next;
      if (rd_acc && is_io && (io_sel == 3'd4)) snapshot <= cycle_cnt;
      if (push_ok) wr_ptr <= wr_ptr + CW'(1);
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      if (cpu_push && !not_full) tx_overflow <= 1'b1;
      if (stop_wr) program_stop <= 1'b1;
      if (stop_wr) begin
        stop_pend <= 1'b1;
      end else if (stop_pend && !cpu_push && not_full) begin
        stop_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: directed stimulus, a transaction-level
// model (assoc-array RAM, byte queue FIFO, cycle count) checked every cycle,
// plus hand-computed literal expectations.
module tb_ram_io_responder;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] bus_a;
  logic [7:0]  bus_wdata;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;
  logic        tx_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_io_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .bus_a          (bus_a),
    .bus_wdata      (bus_wdata),
    .bus_wr         (bus_wr),
    .bus_rdata      (bus_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  ram_m [int];
  logic [7:0]  q [$];
  logic [7:0]  m_rdata = 8'h00;
  bit          m_known = 1'b1;
  bit          m_stop = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_snap = 32'd0;

  always @(posedge clk or negedge rst_n) begin : model
    bit is_io, was_full, do_pop, cpu_push, new_stop;
    int addr;
    if (!rst_n) begin
      q.delete();
      m_rdata = 8'h00; m_known = 1'b1; m_stop = 1'b0; m_ovf = 1'b0;
      m_pend = 1'b0; m_cnt = 32'd0; m_snap = 32'd0;
    end else begin
      is_io    = (bus_a[17:16] == 2'b11);
      addr     = int'(bus_a[16:0]);
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && tx_ready;
      cpu_push = 1'b0;
      new_stop = 1'b0;
      if (rdy) begin
        if (bus_wr) begin
          if (!is_io) ram_m[addr] = bus_wdata;
          else if (bus_a[2:0] == 3'd0) cpu_push = (bus_wdata != 8'h00);
          else if (bus_a[2:0] == 3'd4) new_stop = 1'b1;
        end else if (!is_io) begin
          m_known = ram_m.exists(addr);
          if (m_known) m_rdata = ram_m[addr];
        end else begin
          m_known = 1'b1;
          case (bus_a[2:0])
            3'd0: m_rdata = rx_valid ? rx_data : 8'h00;
            3'd4: begin m_rdata = m_cnt[7:0]; m_snap = m_cnt; end
            3'd5: m_rdata = m_snap[15:8];
            3'd6: m_rdata = m_snap[23:16];
            3'd7: m_rdata = m_snap[31:24];
            default: m_rdata = 8'h00;
          endcase
        end
      end
      if (do_pop) void'(q.pop_front());
      if (cpu_push) begin
        if (was_full) m_ovf = 1'b1;
        else q.push_back(bus_wdata);
      end else if (m_pend && !was_full) begin
        q.push_back(8'h00);
        m_pend = 1'b0;
      end
      if (new_stop) begin m_stop = 1'b1; m_pend = 1'b1; end
      m_cnt = m_cnt + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_known) chk("bus_rdata", 32'(bus_rdata), 32'(m_rdata));
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(q.size() == DEPTH));
    chk("program_stop", 32'(program_stop), 32'(m_stop));
    chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    chk("rx_pop", 32'(rx_pop),
        32'(rst_n && rdy && !bus_wr && (bus_a[17:16] == 2'b11) && (bus_a[2:0] == 3'd0) && rx_valid));
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
    rdy = r; bus_a = a; bus_wr = w; bus_wdata = d;
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [7:0] b0, b1, b2, b3;
    rst_n = 1'b1; rdy = 1'b0; bus_a = 32'd0; bus_wr = 1'b0; bus_wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", 32'(bus_rdata), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_full", 32'(io_buffer_full), 32'h0);
    chk("rst_stop", 32'(program_stop), 32'h0);
    chk("rst_ovf", 32'(tx_overflow), 32'h0);
    rst_n = 1'b1;

    // Counter snapshot: five edges after release the counter reads 5
    repeat (5) drive(1'b0, 32'h0, 1'b0, 8'h00);
    drive(1'b1, 32'h30004, 1'b0, 8'h00); b0 = bus_rdata;
    drive(1'b1, 32'h30005, 1'b0, 8'h00); b1 = bus_rdata;
    drive(1'b1, 32'h30006, 1'b0, 8'h00); b2 = bus_rdata;
    drive(1'b1, 32'h30007, 1'b0, 8'h00); b3 = bus_rdata;
    chk("lit_snapshot", {b3, b2, b1, b0}, 32'd5);
    drive(1'b1, 32'h30002, 1'b0, 8'h00);
    chk("lit_io_other", 32'(bus_rdata), 32'h0);

    // RAM write/read, including the top RAM byte and read-data hold
    drive(1'b1, 32'h00010, 1'b1, 8'hA5);
    chk("lit_no_read_yet", 32'(bus_rdata), 32'h0);
    drive(1'b1, 32'h00010, 1'b0, 8'h00);
    chk("lit_ram_a5", 32'(bus_rdata), 32'hA5);
    drive(1'b1, 32'h1FFFF, 1'b1, 8'h3C);
    drive(1'b1, 32'h1FFFF, 1'b0, 8'h00);
    chk("lit_ram_3c", 32'(bus_rdata), 32'h3C);
    drive(1'b0, 32'h00010, 1'b0, 8'h00);
    chk("lit_rdata_hold", 32'(bus_rdata), 32'h3C);

    // TX: 'H','i',0x00 with tx_ready low, then drain
    drive(1'b1, 32'h30000, 1'b1, 8'h48);
    drive(1'b1, 32'h30000, 1'b1, 8'h69);
    drive(1'b1, 32'h30000, 1'b1, 8'h00);
    chk("lit_tx_valid", 32'(tx_valid), 32'h1);
    chk("lit_tx_head_H", 32'(tx_data), 32'h48);
    tx_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_tx_head_i", 32'(tx_data), 32'h69);
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_tx_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Fill to full, overflow on the ninth push
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 32'h30000, 1'b1, 8'(i));
      if (i == 8) begin
        chk("lit_full_at_8", 32'(io_buffer_full), 32'h1);
        chk("lit_no_ovf_at_8", 32'(tx_overflow), 32'h0);
      end
    end
    chk("lit_ovf", 32'(tx_overflow), 32'h1);
    chk("lit_head_1", 32'(tx_data), 32'h01);
    // Pop and push on a full FIFO: pop taken, push dropped
    tx_ready = 1'b1;
    drive(1'b1, 32'h30000, 1'b1, 8'h55);
    tx_ready = 1'b0;
    chk("lit_popfull_not_full", 32'(io_buffer_full), 32'h0);
    chk("lit_popfull_head", 32'(tx_data), 32'h02);
    drive(1'b1, 32'h30000, 1'b1, 8'h0A);
    chk("lit_refull", 32'(io_buffer_full), 32'h1);

    // Stop while full: latch now, 0x00 queued once room appears
    drive(1'b1, 32'h30004, 1'b1, 8'h77);
    chk("lit_stop", 32'(program_stop), 32'h1);
    chk("lit_stop_full", 32'(io_buffer_full), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    tx_ready = 1'b0;
    chk("lit_after_pop_full", 32'(io_buffer_full), 32'h0);
    chk("lit_after_pop_head", 32'(tx_data), 32'h03);
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_stop_byte_in", 32'(io_buffer_full), 32'h1);
    tx_ready = 1'b1;
    repeat (7) drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_last_is_zero", 32'(tx_data), 32'h00);
    chk("lit_last_valid", 32'(tx_valid), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Reset mid-stream discards queued bytes and the stop latch
    drive(1'b1, 32'h30000, 1'b1, 8'h11);
    drive(1'b1, 32'h30000, 1'b1, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_flush", 32'(tx_valid), 32'h0);
    chk("lit_rst_stop", 32'(program_stop), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h30004, 1'b1, 8'h05);
    drive(1'b0, 32'h30000, 1'b1, 8'h33);
    drive(1'b0, 32'h00010, 1'b1, 8'hFF);
    drive(1'b0, 32'h0, 1'b0, 8'h00);
    chk("lit_rdy0_stop", 32'(program_stop), 32'h0);
    chk("lit_rdy0_push", 32'(tx_valid), 32'h0);
    drive(1'b1, 32'h00010, 1'b0, 8'h00);
    chk("lit_rdy0_ram", 32'(bus_rdata), 32'hA5);

    // RX port
    rx_valid = 1'b1; rx_data = 8'h41;
    rdy = 1'b1; bus_a = 32'h30000; bus_wr = 1'b0;
    #2;
    chk("lit_rx_pop", 32'(rx_pop), 32'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rdy = 1'b0;
    #2;
    chk("lit_rx_pop_gone", 32'(rx_pop), 32'h0);
    chk("lit_rx_data", 32'(bus_rdata), 32'h41);
    drive(1'b1, 32'h30000, 1'b0, 8'h00);
    chk("lit_rx_empty", 32'(bus_rdata), 32'h00);
    rx_valid = 1'b1; rx_data = 8'h7E;
    rdy = 1'b0;
    #2;
    chk("lit_rx_rdy0", 32'(rx_pop), 32'h0);
    drive(1'b0, 32'h30000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
